// File: rtl/pipelined_barrel_shifter.sv
// Barrel shifter with one registered stage per shift-amount bit. Each stage has
// its own valid/ready handshake, so a stall at the output only backs up as far as needed.
module pipelined_barrel_shifter #(
    parameter  int DATA_LENGTH = 16,
    localparam int STAGES      = $clog2(DATA_LENGTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_LENGTH-1:0] data_in,
    input  logic                   right,
    input  logic                   arith,
    input  logic                   rotate,
    input  logic [STAGES-1:0]      sa,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_LENGTH-1:0] data_out,
    output logic                   zero
);

    logic [STAGES-1:0]      valid_q;
    logic [DATA_LENGTH-1:0] data_q     [STAGES];
    logic [STAGES-2:0]      right_q;
    logic [STAGES-2:0]      arith_q;
    logic [STAGES-2:0]      rotate_q;
    logic [STAGES-1:0]      sa_q       [STAGES-1];

    logic [STAGES-1:0]      stageReady;
    logic [STAGES-1:0]      srcValid;
    logic [STAGES-1:0]      srcRight;
    logic [STAGES-1:0]      srcArith;
    logic [STAGES-1:0]      srcRotate;
    logic [DATA_LENGTH-1:0] srcData    [STAGES];
    logic [STAGES-1:0]      srcSa      [STAGES];
    logic [DATA_LENGTH-1:0] data_d     [STAGES];

    function automatic logic [DATA_LENGTH-1:0] shiftStage(
        input logic [DATA_LENGTH-1:0] value,
        input int                     amount,
        input logic                   enable,
        input logic                   isRight,
        input logic                   isArith,
        input logic                   isRotate
    );
        logic [DATA_LENGTH-1:0] result;
        result = value;
        if (enable) begin
            if (isRotate) begin
                if (isRight)
                    result = (value >> amount) | (value << (DATA_LENGTH - amount));
                else
                    result = (value << amount) | (value >> (DATA_LENGTH - amount));
            end else if (!isRight) begin
                result = value << amount;
            end else if (isArith) begin
                // The current MSB still equals the original sign, so >>> fills correctly
                result = $signed(value) >>> amount;
            end else begin
                result = value >> amount;
            end
        end
        return result;
    endfunction

    // A stage may load unless it and every stage after it are full while the output stalls
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            stageReady[k] = out_ready;
            for (int j = k; j < STAGES; j++) begin
                if (!valid_q[j])
                    stageReady[k] = 1'b1;
            end
        end
    end

    always_comb begin
        srcValid[0]  = in_valid;
        srcData[0]   = data_in;
        srcRight[0]  = right;
        srcArith[0]  = arith;
        srcRotate[0] = rotate;
        srcSa[0]     = sa;
        for (int k = 1; k < STAGES; k++) begin
            srcValid[k]  = valid_q[k-1];
            srcData[k]   = data_q[k-1];
            srcRight[k]  = right_q[k-1];
            srcArith[k]  = arith_q[k-1];
            srcRotate[k] = rotate_q[k-1];
            srcSa[k]     = sa_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            data_d[k] = shiftStage(srcData[k], 1 << k, srcSa[k][0],
                                   srcRight[k], srcArith[k], srcRotate[k]);
        end
    end

    // The sa field is shifted down each stage so bit 0 always selects the current stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= '0;
            right_q  <= '0;
            arith_q  <= '0;
            rotate_q <= '0;
            for (int k = 0; k < STAGES; k++)
                data_q[k] <= '0;
            for (int k = 0; k < STAGES - 1; k++)
                sa_q[k] <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (stageReady[k]) begin
                    valid_q[k] <= srcValid[k];
                    if (srcValid[k])
                        data_q[k] <= data_d[k];
                end
            end
            for (int k = 0; k < STAGES - 1; k++) begin
                if (stageReady[k] && srcValid[k]) begin
                    right_q[k]  <= srcRight[k];
                    arith_q[k]  <= srcArith[k];
                    rotate_q[k] <= srcRotate[k];
                    sa_q[k]     <= srcSa[k] >> 1;
                end
            end
        end
    end

    assign in_ready  = stageReady[0];
    assign out_valid = valid_q[STAGES-1];
    assign data_out  = data_q[STAGES-1];
    assign zero      = ~|data_q[STAGES-1];

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Self-checking bench for pipelined_barrel_shifter at DATA_LENGTH=8: directed
// scenarios with literal results plus a long random run against a bit-level model.
module tb_pipelined_barrel_shifter;

    localparam int W  = 8;
    localparam int ST = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] data_in;
    logic         right;
    logic         arith;
    logic         rotate;
    logic [ST-1:0] sa;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] data_out;
    logic         zero;

    int tests      = 0;
    int fails      = 0;
    int cycleCnt   = 0;
    int lastAccept = 0;

    typedef struct {
        logic [W-1:0] res;
        int           acc;
    } exp_t;

    exp_t         expQ[$];
    exp_t         e;
    logic         holdPending = 1'b0;
    logic [W-1:0] holdData    = '0;

    pipelined_barrel_shifter #(.DATA_LENGTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .right     (right),
        .arith     (arith),
        .rotate    (rotate),
        .sa        (sa),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Result bit i is picked from the source bit it must come from, or the fill value
    function automatic logic [W-1:0] modelShift(input logic [W-1:0] d, input logic isRight,
                                                input logic isArith, input logic isRotate,
                                                input int s);
        logic [W-1:0] o;
        for (int i = 0; i < W; i++) begin
            if (isRotate)
                o[i] = isRight ? d[(i + s) % W] : d[(i - s + W) % W];
            else if (!isRight)
                o[i] = (i >= s) ? d[i - s] : 1'b0;
            else
                o[i] = (i + s < W) ? d[i + s] : (isArith ? d[W-1] : 1'b0);
        end
        return o;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: actual 0x%0h, required 0x%0h (cycle %0d)",
                     name, actual, expected, cycleCnt);
        end
    endtask

    task automatic applyStimulus(input logic [W-1:0] d, input logic r, input logic a,
                                 input logic rot, input logic [ST-1:0] s);
        bit done = 1'b0;
        data_in  = d;
        right    = r;
        arith    = a;
        rotate   = rot;
        sa       = s;
        in_valid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                done       = 1'b1;
                lastAccept = cycleCnt;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            tests++;
            fails++;
            $display("[TB] FAIL accept_timeout: input 0x%0h never accepted", d);
        end
    endtask

    task automatic waitOutValid(input string name, output int lat);
        bit seen = 1'b0;
        lat = -1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                lat  = cycleCnt - lastAccept;
            end
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("[TB] FAIL %s: out_valid never rose, required within 20 cycles", name);
        end
    endtask

    // Scoreboard: queue a model result on every input transfer, pop on every output transfer
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            expQ.delete();
            holdPending <= 1'b0;
        end else begin
            if (holdPending)
                checkOutput("hold_stable", 32'({out_valid, data_out}), 32'({1'b1, holdData}));
            if (in_valid && in_ready)
                expQ.push_back('{modelShift(data_in, right, arith, rotate, int'(sa)), cycleCnt});
            if (out_valid) begin
                checkOutput("zero_flag", 32'(zero), 32'(data_out == 8'h00));
                if (out_ready) begin
                    if (expQ.size() == 0) begin
                        tests++;
                        fails++;
                        $display("[TB] FAIL unexpected_output: actual 0x%0h, required no output",
                                 data_out);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("data_out", 32'(data_out), 32'(e.res));
                        tests++;
                        if (cycleCnt - e.acc < ST) begin
                            fails++;
                            $display("[TB] FAIL min_latency: actual %0d, required >= %0d",
                                     cycleCnt - e.acc, ST);
                        end
                    end
                end
            end
            holdPending <= out_valid && !out_ready;
            holdData    <= data_out;
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        int stale;
        int opsSent;
        int cyc;
        bit acc;
        int pick;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        data_in   = '0;
        right     = 1'b0;
        arith     = 1'b0;
        rotate    = 1'b0;
        sa        = '0;
        out_ready = 1'b1;

        // Hand-computed values pinning the model
        checkOutput("model_asr3",   32'(modelShift(8'h96, 1'b1, 1'b1, 1'b0, 3)), 32'hF2);
        checkOutput("model_rotl3",  32'(modelShift(8'h96, 1'b0, 1'b0, 1'b1, 3)), 32'hB4);
        checkOutput("model_rotr1",  32'(modelShift(8'h96, 1'b1, 1'b0, 1'b1, 1)), 32'h4B);
        checkOutput("model_shl1",   32'(modelShift(8'h96, 1'b0, 1'b1, 1'b0, 1)), 32'h2C);
        checkOutput("model_lsr7",   32'(modelShift(8'h80, 1'b1, 1'b0, 1'b0, 7)), 32'h01);
        checkOutput("model_asr7",   32'(modelShift(8'h80, 1'b1, 1'b1, 1'b0, 7)), 32'hFF);
        checkOutput("model_lsr1",   32'(modelShift(8'h01, 1'b1, 1'b0, 1'b0, 1)), 32'h00);
        checkOutput("model_rotl7",  32'(modelShift(8'h96, 1'b0, 1'b0, 1'b1, 7)), 32'h4B);
        checkOutput("model_rotr7",  32'(modelShift(8'h96, 1'b1, 1'b0, 1'b1, 7)), 32'h2D);
        checkOutput("model_sa0",    32'(modelShift(8'h96, 1'b1, 1'b1, 1'b0, 0)), 32'h96);

        // Reset state, observed while rst_n is still low
        repeat (2) @(posedge clk);
        #2;
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_data_out",  32'(data_out),  32'd0);
        checkOutput("reset_zero",      32'(zero),      32'd1);
        checkOutput("reset_in_ready",  32'(in_ready),  32'd1);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // First operation after reset: exact latency and arithmetic result
        applyStimulus(8'h96, 1'b1, 1'b1, 1'b0, 3'd3);
        in_valid = 1'b0;
        waitOutValid("asr_wait", lat);
        checkOutput("latency_first", 32'(lat), 32'd3);
        checkOutput("asr_result", 32'(data_out), 32'hF2);
        @(posedge clk);
        #1;

        // Back-to-back rotates and a left shift with arith set
        applyStimulus(8'h96, 1'b0, 1'b0, 1'b1, 3'd3);
        applyStimulus(8'h96, 1'b1, 1'b0, 1'b1, 3'd1);
        applyStimulus(8'h96, 1'b0, 1'b1, 1'b0, 3'd1);
        in_valid = 1'b0;
        waitOutValid("b2b_wait", lat);
        checkOutput("b2b_first",  32'({out_valid, data_out}), 32'h1B4);
        @(negedge clk);
        checkOutput("b2b_second", 32'({out_valid, data_out}), 32'h14B);
        @(negedge clk);
        checkOutput("b2b_third",  32'({out_valid, data_out}), 32'h12C);
        @(posedge clk);
        #1;

        // Fill boundaries at sa = 7 and a result of zero
        applyStimulus(8'h80, 1'b1, 1'b0, 1'b0, 3'd7);
        applyStimulus(8'h80, 1'b1, 1'b1, 1'b0, 3'd7);
        applyStimulus(8'h01, 1'b1, 1'b0, 1'b0, 3'd1);
        in_valid = 1'b0;
        waitOutValid("edge_wait", lat);
        checkOutput("lsr7_result", 32'({out_valid, data_out}), 32'h101);
        @(negedge clk);
        checkOutput("asr7_result", 32'({out_valid, data_out}), 32'h1FF);
        @(negedge clk);
        checkOutput("zero_result", 32'({out_valid, data_out}), 32'h100);
        checkOutput("zero_set",    32'(zero), 32'd1);
        @(posedge clk);
        #1;

        // Output stall: three held in the pipe, the fourth waits at the input
        out_ready = 1'b0;
        fork
            begin
                applyStimulus(8'h96, 1'b1, 1'b0, 1'b0, 3'd2);
                applyStimulus(8'h96, 1'b1, 1'b1, 1'b0, 3'd1);
                applyStimulus(8'h96, 1'b0, 1'b0, 1'b1, 3'd4);
                applyStimulus(8'h96, 1'b0, 1'b0, 1'b0, 3'd0);
                in_valid = 1'b0;
            end
            begin
                repeat (4) @(negedge clk);
                checkOutput("stall_in_ready",  32'(in_ready), 32'd0);
                checkOutput("stall_held",      32'({out_valid, data_out}), 32'h125);
                @(negedge clk);
                checkOutput("stall_in_ready2", 32'(in_ready), 32'd0);
                checkOutput("stall_stable",    32'({out_valid, data_out}), 32'h125);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
                @(negedge clk);
                checkOutput("drain_first",  32'({out_valid, data_out}), 32'h125);
                @(negedge clk);
                checkOutput("drain_second", 32'({out_valid, data_out}), 32'h1CB);
                @(negedge clk);
                checkOutput("drain_third",  32'({out_valid, data_out}), 32'h169);
                @(negedge clk);
                checkOutput("drain_fourth", 32'({out_valid, data_out}), 32'h196);
            end
        join
        @(posedge clk);
        #1;

        // Asynchronous reset while two operations are in flight
        applyStimulus(8'h0F, 1'b0, 1'b0, 1'b0, 3'd2);
        applyStimulus(8'hF0, 1'b1, 1'b1, 1'b0, 3'd2);
        in_valid = 1'b0;
        waitOutValid("flight_wait", lat);
        checkOutput("flight_first", 32'(data_out), 32'h3C);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_out_valid", 32'(out_valid), 32'd0);
        checkOutput("async_in_ready",  32'(in_ready),  32'd1);
        checkOutput("async_data_out",  32'(data_out),  32'd0);
        checkOutput("async_zero",      32'(zero),      32'd1);
        #1;
        rst_n = 1'b1;
        stale = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        checkOutput("no_stale", 32'(stale), 32'd0);
        @(posedge clk);
        #1;
        applyStimulus(8'h3C, 1'b1, 1'b0, 1'b1, 3'd2);
        in_valid = 1'b0;
        waitOutValid("post_reset_wait", lat);
        checkOutput("latency_post_reset", 32'(lat), 32'd3);
        checkOutput("post_reset_result",  32'(data_out), 32'h0F);
        @(posedge clk);
        #1;

        // Random traffic with random backpressure, checked by the scoreboard
        opsSent = 0;
        cyc     = 0;
        while (opsSent < 10000 && cyc < 60000) begin
            out_ready = ($urandom_range(0, 99) < 70);
            if (!in_valid && ($urandom_range(0, 99) < 75)) begin
                pick = int'($urandom_range(0, 7));
                case (pick)
                    0:       data_in = 8'h00;
                    1:       data_in = 8'h80;
                    2:       data_in = 8'hFF;
                    3:       data_in = 8'h7F;
                    default: data_in = 8'($urandom_range(0, 255));
                endcase
                right    = 1'($urandom_range(0, 1));
                arith    = 1'($urandom_range(0, 1));
                rotate   = 1'($urandom_range(0, 1));
                sa       = 3'($urandom_range(0, 7));
                in_valid = 1'b1;
            end
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                opsSent++;
                in_valid = 1'b0;
            end
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("random_ops_sent", 32'(opsSent), 32'd10000);
        checkOutput("random_drained",  32'(expQ.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
